// File: rtl/instruction_memory_port_if.sv
// Fetch-side lookup signals and backing-memory read bus of the instruction memory port.
// The slave modport is the port's own view; the master modport is the surrounding fetch/bus side.
interface instruction_memory_port_if;
    logic [31:0] instructionAddress;
    logic        invalidate;
    logic        instructionDataValid;
    logic [31:0] instructionData;
    logic        memoryRequest;
    logic [31:0] memoryAddress;
    logic        memoryReady;
    logic        memoryReadValid;
    logic [31:0] memoryReadData;

    modport slave (
        input  instructionAddress,
        input  invalidate,
        input  memoryReady,
        input  memoryReadValid,
        input  memoryReadData,
        output instructionDataValid,
        output instructionData,
        output memoryRequest,
        output memoryAddress
    );

    modport master (
        output instructionAddress,
        output invalidate,
        output memoryReady,
        output memoryReadValid,
        output memoryReadData,
        input  instructionDataValid,
        input  instructionData,
        input  memoryRequest,
        input  memoryAddress
    );
endinterface

// File: rtl/instruction_memory_port.sv
// Instruction fetch responder: direct-mapped one-word-per-line cache with combinational hits
// and a single outstanding refill transaction on the backing memory bus.
module instruction_memory_port #(
    parameter int ENTRIES      = 64,
    parameter int MISS_TIMEOUT = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_memory_port_if.slave   bus
);
    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = 30 - INDEX_BITS;
    localparam int CNT_W      = (MISS_TIMEOUT > 0) ? $clog2(MISS_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MISS_TIMEOUT > 0) ? CNT_W'(MISS_TIMEOUT - 1) : {CNT_W{1'b0}};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_FILL    = 2'd3;

    // Even parity over a stored line; a corrupted line simply reads as a miss.
    function automatic logic calc_parity(input logic [TAG_BITS-1:0] tag, input logic [31:0] data);
        calc_parity = ^{tag, data};
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic                  req_r;
    logic [31:0]           miss_addr_r;
    logic                  flush_pending_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [31:0]           fill_data_r;

    logic [ENTRIES-1:0]    valid_r;
    logic [TAG_BITS-1:0]   tag_r  [ENTRIES];
    logic [31:0]           data_r [ENTRIES];
    logic                  par_r  [ENTRIES];

    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  line_ok_s;
    logic                  hit_s;
    logic                  miss_start_s;
    logic                  timeout_s;
    logic [INDEX_BITS-1:0] fill_index_s;
    logic [TAG_BITS-1:0]   fill_tag_s;
    logic                  fill_we_s;
    logic                  unused_addr_bits_s;

    assign index_s   = bus.instructionAddress[INDEX_BITS+1:2];
    assign tag_s     = bus.instructionAddress[31:INDEX_BITS+2];
    assign line_ok_s = valid_r[index_s]
                    && (tag_r[index_s] == tag_s)
                    && (par_r[index_s] == calc_parity(tag_r[index_s], data_r[index_s]));

    // Hits are only reported while idle; an invalidate pulse masks the hit in its own cycle.
    assign hit_s        = (state_r == ST_IDLE) && line_ok_s && !bus.invalidate;
    assign miss_start_s = (state_r == ST_IDLE) && !line_ok_s && !bus.invalidate;
    assign timeout_s    = (MISS_TIMEOUT > 0) && (cnt_r == CNT_LAST);

    assign fill_index_s = miss_addr_r[INDEX_BITS+1:2];
    assign fill_tag_s   = miss_addr_r[31:INDEX_BITS+2];
    assign fill_we_s    = (state_r == ST_FILL) && !flush_pending_r && !bus.invalidate;

    assign unused_addr_bits_s = &{1'b0, bus.instructionAddress[1:0]};

    assign bus.instructionDataValid = hit_s;
    assign bus.instructionData      = hit_s ? data_r[index_s] : 32'h0000_0000;
    assign bus.memoryRequest        = req_r;
    assign bus.memoryAddress        = miss_addr_r;

    // Next-state decode of the refill sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_start_s) begin
                    state_s = ST_REQUEST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (bus.memoryReady) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQUEST;
                end
            end
            ST_WAIT: begin
                if (bus.memoryReadValid) begin
                    state_s = ST_FILL;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, bus request, miss address, flush tracking, timeout counter and fill data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            req_r           <= 1'b0;
            miss_addr_r     <= 32'h0000_0000;
            flush_pending_r <= 1'b0;
            cnt_r           <= {CNT_W{1'b0}};
            fill_data_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            req_r   <= (state_s == ST_REQUEST);

            if (miss_start_s) begin
                miss_addr_r <= {bus.instructionAddress[31:2], 2'b00};
            end else begin
                miss_addr_r <= miss_addr_r;
            end

            // A flush seen mid-transaction must suppress the pending fill of a stale line.
            if (state_s == ST_IDLE) begin
                flush_pending_r <= 1'b0;
            end else if (bus.invalidate && (state_r != ST_IDLE)) begin
                flush_pending_r <= 1'b1;
            end else begin
                flush_pending_r <= flush_pending_r;
            end

            if (state_r != ST_WAIT) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (!timeout_s) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end

            if ((state_r == ST_WAIT) && bus.memoryReadValid) begin
                fill_data_r <= bus.memoryReadData;
            end else begin
                fill_data_r <= fill_data_r;
            end
        end
    end

    // Line valid bits: the only reset cache storage; invalidate wins over a coincident fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (bus.invalidate) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (fill_we_s) begin
            valid_r[fill_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag, data and parity arrays are written only on a fill and never reset.
    always_ff @(posedge clock) begin
        if (fill_we_s) begin
            tag_r[fill_index_s]  <= fill_tag_s;
            data_r[fill_index_s] <= fill_data_r;
            par_r[fill_index_s]  <= calc_parity(fill_tag_s, fill_data_r);
        end
    end
endmodule

// File: tb/tb_instruction_memory_port.sv
// Directed self-checking bench for instruction_memory_port (ENTRIES=64, MISS_TIMEOUT=8).
module tb_instruction_memory_port;
    logic clock = 1'b0;
    logic reset;
    int   check_count    = 0;
    int   error_count    = 0;
    int   accepted_count = 0;

    instruction_memory_port_if bus_if ();

    instruction_memory_port #(.ENTRIES(64), .MISS_TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    // Count handshakes accepted by the backing bus.
    always @(posedge clock) begin
        if (bus_if.memoryRequest && bus_if.memoryReady) accepted_count++;
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] data);
        check_value({tag, "_valid"}, 32'(bus_if.instructionDataValid), 32'd1);
        check_value({tag, "_data"}, bus_if.instructionData, data);
    endtask

    task automatic expect_miss(input string tag);
        check_value({tag, "_valid"}, 32'(bus_if.instructionDataValid), 32'd0);
        check_value({tag, "_data"}, bus_if.instructionData, 32'h0000_0000);
    endtask

    // Wait for the request, hold it off for nready cycles, then accept; returns in first WAIT cycle.
    task automatic serve_req(input string tag, input logic [31:0] addr, input int nready);
        int n = 0;
        bus_if.memoryReady = 1'b0;
        #1;
        while (bus_if.memoryRequest !== 1'b1 && n < 20) begin
            cyc();
            #1;
            n++;
        end
        check_value({tag, "_req"}, 32'(bus_if.memoryRequest), 32'd1);
        check_value({tag, "_addr"}, bus_if.memoryAddress, addr);
        for (int i = 0; i < nready; i++) begin
            check_value({tag, "_hold_req"}, 32'(bus_if.memoryRequest), 32'd1);
            check_value({tag, "_hold_addr"}, bus_if.memoryAddress, addr);
            cyc();
            #1;
        end
        bus_if.memoryReady = 1'b1;
        cyc();
        bus_if.memoryReady = 1'b0;
    endtask

    // From the first WAIT cycle: nwait idle cycles, one response, FILL, then back in IDLE.
    task automatic serve_resp(input string tag, input int nwait, input logic [31:0] data);
        for (int i = 0; i < nwait; i++) cyc();
        bus_if.memoryReadValid = 1'b1;
        bus_if.memoryReadData  = data;
        cyc();
        bus_if.memoryReadValid = 1'b0;
        bus_if.memoryReadData  = 32'h0000_0000;
        #1;
        check_value({tag, "_fill_valid"}, 32'(bus_if.instructionDataValid), 32'd0);
        cyc();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus_if.instructionAddress = 32'h0000_0100;
        bus_if.invalidate         = 1'b0;
        bus_if.memoryReady        = 1'b0;
        bus_if.memoryReadValid    = 1'b0;
        bus_if.memoryReadData     = 32'h0000_0000;
        cyc();
        cyc();
        #1;
        check_value("rst_dvalid", 32'(bus_if.instructionDataValid), 32'd0);
        check_value("rst_data", bus_if.instructionData, 32'h0000_0000);
        check_value("rst_req", 32'(bus_if.memoryRequest), 32'd0);
        check_value("rst_maddr", bus_if.memoryAddress, 32'h0000_0000);
        reset = 1'b0;

        // Cold miss, response two cycles after acceptance, then a steady hit.
        expect_miss("cold_miss");
        serve_req("cold", 32'h0000_0100, 0);
        serve_resp("cold", 1, 32'h0000_0013);
        expect_hit("cold_hit", 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            expect_hit("cold_hold", 32'h0000_0013);
            check_value("cold_hold_req", 32'(bus_if.memoryRequest), 32'd0);
        end
        check_value("cold_accepts", 32'(accepted_count), 32'd1);

        // 0x100 and 0x200 share index 0 with different tags.
        bus_if.instructionAddress = 32'h0000_0200;
        #1;
        expect_miss("conflict_miss");
        serve_req("conflict", 32'h0000_0200, 0);
        serve_resp("conflict", 0, 32'h0020_0093);
        expect_hit("conflict_hit", 32'h0020_0093);
        bus_if.instructionAddress = 32'h0000_0100;
        #1;
        expect_miss("evicted_miss");
        serve_req("evicted", 32'h0000_0100, 0);
        serve_resp("evicted", 0, 32'h0000_0013);
        expect_hit("evicted_hit", 32'h0000_0013);
        check_value("conflict_accepts", 32'(accepted_count), 32'd3);

        // Redirect to 0x800 while the 0x400 refill is outstanding.
        bus_if.instructionAddress = 32'h0000_0400;
        #1;
        expect_miss("redir_miss");
        serve_req("redir", 32'h0000_0400, 0);
        bus_if.instructionAddress = 32'h0000_0800;
        serve_resp("redir", 1, 32'hAAAA_AAAA);
        expect_miss("redir_no_stale");
        serve_req("redir_new", 32'h0000_0800, 0);
        serve_resp("redir_new", 0, 32'h0080_0093);
        expect_hit("redir_new_hit", 32'h0080_0093);
        check_value("redir_accepts", 32'(accepted_count), 32'd5);

        // Invalidate during WAIT drops the fill and every older line.
        bus_if.instructionAddress = 32'h0000_0040;
        #1;
        expect_miss("inval_miss");
        serve_req("inval", 32'h0000_0040, 0);
        bus_if.invalidate = 1'b1;
        cyc();
        bus_if.invalidate = 1'b0;
        serve_resp("inval", 0, 32'h4000_0013);
        expect_miss("inval_nofill");
        serve_req("inval_refetch", 32'h0000_0040, 0);
        serve_resp("inval_refetch", 0, 32'h0040_0013);
        expect_hit("inval_refetch_hit", 32'h0040_0013);
        bus_if.instructionAddress = 32'h0000_0800;
        #1;
        expect_miss("inval_old_line");
        serve_req("inval_old", 32'h0000_0800, 0);
        serve_resp("inval_old", 0, 32'h0080_0093);
        expect_hit("inval_old_hit", 32'h0080_0093);

        // Invalidate pulse in IDLE masks the hit that cycle and clears the line.
        bus_if.invalidate = 1'b1;
        #1;
        check_value("idle_inval_mask", 32'(bus_if.instructionDataValid), 32'd0);
        cyc();
        bus_if.invalidate = 1'b0;
        #1;
        expect_miss("idle_inval_cleared");
        serve_req("idle_inval", 32'h0000_0800, 0);
        serve_resp("idle_inval", 0, 32'h0080_0093);
        check_value("inval_accepts", 32'(accepted_count), 32'd9);

        // Five cycles of backpressure before the request is accepted.
        bus_if.instructionAddress = 32'h0000_0104;
        #1;
        expect_miss("bp_miss");
        serve_req("bp", 32'h0000_0104, 5);
        serve_resp("bp", 0, 32'h0104_0013);
        expect_hit("bp_hit", 32'h0104_0013);
        check_value("bp_accepts", 32'(accepted_count), 32'd10);

        // Invalidate coincident with FILL suppresses the write.
        bus_if.instructionAddress = 32'h0000_0108;
        serve_req("fillinv", 32'h0000_0108, 0);
        bus_if.memoryReadValid = 1'b1;
        bus_if.memoryReadData  = 32'h5555_5555;
        cyc();
        bus_if.memoryReadValid = 1'b0;
        bus_if.invalidate      = 1'b1;
        cyc();
        bus_if.invalidate = 1'b0;
        #1;
        expect_miss("fillinv_nofill");
        serve_req("fillinv_re", 32'h0000_0108, 0);
        serve_resp("fillinv_re", 0, 32'h0108_0013);
        expect_hit("fillinv_hit", 32'h0108_0013);

        // Reset during WAIT drops the transaction and all valid lines.
        bus_if.instructionAddress = 32'h0000_010C;
        serve_req("rstmid", 32'h0000_010C, 0);
        reset = 1'b1;
        cyc();
        #1;
        check_value("rstmid_req", 32'(bus_if.memoryRequest), 32'd0);
        check_value("rstmid_maddr", bus_if.memoryAddress, 32'h0000_0000);
        reset = 1'b0;
        bus_if.instructionAddress = 32'h0000_0108;
        #1;
        expect_miss("rstmid_cleared");
        serve_req("rstmid_new", 32'h0000_0108, 0);
        serve_resp("rstmid_new", 0, 32'h0108_0013);
        expect_hit("rstmid_hit", 32'h0108_0013);
        check_value("rstmid_accepts", 32'(accepted_count), 32'd14);

        // Timeout after eight silent WAIT cycles; the late response is ignored.
        bus_if.instructionAddress = 32'h0000_0110;
        #1;
        expect_miss("tmo_miss");
        serve_req("tmo", 32'h0000_0110, 0);
        for (int i = 0; i < 7; i++) cyc();
        #1;
        check_value("tmo_wait8_req", 32'(bus_if.memoryRequest), 32'd0);
        cyc();
        bus_if.memoryReadValid = 1'b1;
        bus_if.memoryReadData  = 32'hDEAD_BEEF;
        #1;
        check_value("tmo_idle_req", 32'(bus_if.memoryRequest), 32'd0);
        check_value("tmo_idle_valid", 32'(bus_if.instructionDataValid), 32'd0);
        cyc();
        bus_if.memoryReadValid = 1'b0;
        bus_if.memoryReadData  = 32'h0000_0000;
        serve_req("tmo_retry", 32'h0000_0110, 0);
        serve_resp("tmo_retry", 0, 32'h0110_0013);
        expect_hit("tmo_hit", 32'h0110_0013);
        check_value("final_accepts", 32'(accepted_count), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
